// File: rtl/pipe_latch.sv
// Inter-stage pipeline register with valid/ready handshake, two-entry skid buffer,
// synchronous flush with saturating discard counter, and bubble output when empty.
module pipe_latch #(
    parameter int unsigned          DATA_W = 64,
    parameter logic [DATA_W-1:0]    BUBBLE = '0,
    parameter int unsigned          CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              in_fire;
    logic              out_fire;
    logic [1:0]        occ;
    logic [1:0]        discard;
    logic [CNT_W:0]    cnt_sum;

    // in_ready looks only at registered state, flush and reset, never at out_ready
    assign in_ready  = (state_q != FULL) & ~flush & ~reset;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = out_valid ? main_q : BUBBLE;
    assign flush_cnt = cnt_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;
        occ     = 2'd0;
        discard = 2'd0;
        cnt_sum = '0;

        case (state_q)
            ONE:     occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase

        if (flush) begin
            // A head consumed in the flush cycle is delivered, not discarded
            state_d = EMPTY;
            discard = occ - {1'b0, out_fire};
            cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(discard);
            if (cnt_sum > {1'b0, {CNT_W{1'b1}}}) begin
                cnt_d = '1;
            end else begin
                cnt_d = cnt_sum[CNT_W-1:0];
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_latch.sv
// Directed self-checking bench for pipe_latch; a second instance with a 2-bit
// counter shares all inputs to exercise flush_cnt saturation.
module tb_pipe_latch;

    localparam logic [63:0] BUB = 64'h0000_0000_0000_0013;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] in_data;

    logic        in_ready, out_valid;
    logic [63:0] out_data;
    logic [15:0] flush_cnt;

    logic        in_ready_s, out_valid_s;
    logic [63:0] out_data_s;
    logic [1:0]  flush_cnt_s;

    int vectors    = 0;
    int miscompares = 0;

    pipe_latch #(.DATA_W(64), .BUBBLE(BUB), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flush_cnt(flush_cnt)
    );

    pipe_latch #(.DATA_W(64), .BUBBLE(BUB), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .flush_cnt(flush_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        #2;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        vectors++; if (out_data !== BUB) begin miscompares++; $display("FAIL reset_out_data: got %h expected %h", out_data, BUB); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        vectors++; if (flush_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_flush_cnt: got %0d expected 0", flush_cnt); end
        tick();
        tick();
        reset = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_streaming();
        logic [63:0] exp_d [3];
        exp_d[0] = 64'h1; exp_d[1] = 64'h2; exp_d[2] = 64'h3;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = exp_d[i];
            tick();
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, out_valid); end
            vectors++; if (out_data !== exp_d[i]) begin miscompares++; $display("FAIL stream_data[%0d]: got %h expected %h", i, out_data, exp_d[i]); end
        end
        in_valid = 1'b0;
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_drain_valid: got %b expected 0", out_valid); end
        vectors++; if (out_data !== BUB) begin miscompares++; $display("FAIL stream_drain_data: got %h expected %h", out_data, BUB); end
    endtask

    task automatic test_stall_skid();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'hA;
        tick();
        vectors++; if (out_data !== 64'hA) begin miscompares++; $display("FAIL stall_first: got %h expected a", out_data); end
        out_ready = 1'b0;
        in_data   = 64'hB;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_ready_one: got %b expected 1", in_ready); end
        tick();
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready_full: got %b expected 0", in_ready); end
        vectors++; if (out_data !== 64'hA) begin miscompares++; $display("FAIL stall_hold_a: got %h expected a", out_data); end
        in_data = 64'hC;
        tick();
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready_held: got %b expected 0", in_ready); end
        vectors++; if (out_data !== 64'hA) begin miscompares++; $display("FAIL stall_hold_a2: got %h expected a", out_data); end
        out_ready = 1'b1;
        tick();
        vectors++; if (out_data !== 64'hB) begin miscompares++; $display("FAIL release_b: got %h expected b", out_data); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL release_ready: got %b expected 1", in_ready); end
        tick();
        vectors++; if (out_data !== 64'hC) begin miscompares++; $display("FAIL release_c: got %h expected c", out_data); end
        in_valid = 1'b0;
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL release_drain: got %b expected 0", out_valid); end
    endtask

    task automatic fill_two(input logic [63:0] a, input logic [63:0] b);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = a;
        tick();
        in_data = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_flush_full();
        fill_two(64'h10, 64'h11);
        vectors++; if (out_data !== 64'h10) begin miscompares++; $display("FAIL flush_full_head: got %h expected 10", out_data); end
        in_valid = 1'b1;
        in_data  = 64'h12;
        flush    = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_full_valid: got %b expected 0", out_valid); end
        vectors++; if (out_data !== BUB) begin miscompares++; $display("FAIL flush_full_data: got %h expected %h", out_data, BUB); end
        vectors++; if (flush_cnt !== 16'd2) begin miscompares++; $display("FAIL flush_full_cnt: got %0d expected 2", flush_cnt); end
        vectors++; if (flush_cnt_s !== 2'd2) begin miscompares++; $display("FAIL flush_full_cnt_small: got %0d expected 2", flush_cnt_s); end
    endtask

    task automatic test_flush_consume();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'h20;
        tick();
        vectors++; if (out_data !== 64'h20) begin miscompares++; $display("FAIL consume_head: got %h expected 20", out_data); end
        in_data = 64'h21;
        flush   = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL consume_in_ready: got %b expected 0", in_ready); end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        vectors++; if (flush_cnt !== 16'd2) begin miscompares++; $display("FAIL consume_cnt: got %0d expected 2", flush_cnt); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL consume_valid: got %b expected 0", out_valid); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL consume_not_accepted: got %b expected 0", out_valid); end
    endtask

    task automatic test_saturation();
        logic [15:0] exp_big;
        for (int k = 1; k <= 4; k++) begin
            fill_two(64'h100 + 64'(k), 64'h200 + 64'(k));
            flush = 1'b1;
            tick();
            flush = 1'b0;
            exp_big = 16'(2 + 2 * k);
            vectors++; if (flush_cnt_s !== 2'd3) begin miscompares++; $display("FAIL sat_small[%0d]: got %0d expected 3", k, flush_cnt_s); end
            vectors++; if (flush_cnt !== exp_big) begin miscompares++; $display("FAIL sat_big[%0d]: got %0d expected %0d", k, flush_cnt, exp_big); end
        end
    endtask

    task automatic test_async_reset();
        fill_two(64'h30, 64'h31);
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL areset_full: got %b expected 0", in_ready); end
        #2;
        reset = 1'b1;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL areset_valid: got %b expected 0", out_valid); end
        vectors++; if (out_data !== BUB) begin miscompares++; $display("FAIL areset_data: got %h expected %h", out_data, BUB); end
        vectors++; if (flush_cnt !== 16'd0) begin miscompares++; $display("FAIL areset_cnt: got %0d expected 0", flush_cnt); end
        vectors++; if (flush_cnt_s !== 2'd0) begin miscompares++; $display("FAIL areset_cnt_small: got %0d expected 0", flush_cnt_s); end
        tick();
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL areset_ready_high: got %b expected 0", in_ready); end
        reset = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL areset_ready_release: got %b expected 1", in_ready); end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'h40;
        tick();
        in_valid = 1'b0;
        vectors++; if (out_data !== 64'h40) begin miscompares++; $display("FAIL areset_resume: got %h expected 40", out_data); end
        vectors++; if (flush_cnt !== 16'd0) begin miscompares++; $display("FAIL areset_cnt_after: got %0d expected 0", flush_cnt); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall_skid();
        test_flush_full();
        test_flush_consume();
        test_saturation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_latch.md
# pipe_latch

Parametrised inter-stage pipeline register for the MIPS pipeline. It is the generalised form of the fixed IF/ID latch and can be instantiated at IF/ID, ID/EX, EX/MEM or MEM/WB. It carries an arbitrary-width payload under a valid/ready handshake, with stall back-pressure, synchronous flush, and bubble injection. A two-entry skid buffer keeps `in_ready` free of any combinational path from `out_ready`, so stalls can propagate backwards without long timing chains.

## Interface

Parameters:
- `DATA_W`, default 64: payload width, for example `{next_pc, instr}` at IF/ID.
- `BUBBLE`, default 0: `DATA_W`-bit value driven on `out_data` when not valid (a NOP encoding).
- `CNT_W`, default 16: width of the flush-discard counter.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `reset`, input, 1: reset, asynchronous, active-high.
- `flush`, input, 1: synchronous squash of all held entries (branch or jump redirect).
- `in_valid`, input, 1: upstream stage offers `in_data`.
- `in_ready`, output, 1: latch accepts this cycle.
- `in_data`, input, `DATA_W`: upstream payload.
- `out_valid`, output, 1: `out_data` holds a real entry.
- `out_ready`, input, 1: downstream consumes this cycle (deasserted means stall).
- `out_data`, output, `DATA_W`: head entry, or `BUBBLE` when `out_valid` is 0.
- `flush_cnt`, output, `CNT_W`: saturating count of valid entries discarded by flush.

## Operation

Definitions:
- `in_fire` = `in_valid & in_ready`.
- `out_fire` = `out_valid & out_ready`.
- Storage: a main register (head) and a skid register.
- State: EMPTY (0 entries), ONE (main valid), FULL (main and skid valid).

Output equations:
- `in_ready` = (state != FULL) & !`flush` & !`reset`.
- `out_valid` = (state != EMPTY).
- `out_data` = main if `out_valid`, else `BUBBLE`.

Transitions when `flush` = 0:
- EMPTY: on `in_fire`, main <= `in_data` and go to ONE. Otherwise stay in EMPTY.
- ONE, `in_fire` & `out_fire`: main <= `in_data`; stay in ONE.
- ONE, `in_fire` only: skid <= `in_data`; go to FULL.
- ONE, `out_fire` only: go to EMPTY.
- ONE, neither: hold.
- FULL: `in_ready` = 0. On `out_fire`, main <= skid and go to ONE. Otherwise hold.

Flush:
- Highest priority: next state is EMPTY regardless of `in_valid` or `out_ready`.
- Because `in_ready` is 0, no input is accepted in the flush cycle.
- `flush_cnt` += entries discarded. Entries discarded = occupancy, minus 1 if `out_fire` in the same cycle (a consumed head is not counted as discarded).
- `flush_cnt` saturates at 2^`CNT_W`−1 and does not wrap.

Ordering:
- Strict FIFO order is preserved: the skid entry is always younger than main.
- No payload is duplicated or dropped except by flush.

Reset:
- State goes to EMPTY, main and skid go to `BUBBLE`, `flush_cnt` goes to 0.
- The resulting outputs are `out_valid` = 0, `out_data` = `BUBBLE`, `in_ready` = 0 while `reset` is high and 1 from the first cycle after release.
- Reset asserted mid-operation discards contents immediately (asynchronously) and does not increment `flush_cnt`.

## Timing

- Latency: 1 cycle. Data accepted at edge N appears on `out_data` with `out_valid` = 1 after edge N.
- Throughput: 1 entry per cycle while `out_ready` stays high.
- Stall absorption:
  - `out_ready` drops, so the edge-N entry stays in main.
  - `in_ready` is still 1 in the next cycle (ONE), so one more entry goes into skid.
  - `in_ready` is 0 from the following cycle, when the state is FULL.
- `in_ready` depends only on registered state plus `flush` and `reset`. There is no combinational path from `out_ready` or `in_valid`.
- `out_data` and `out_valid` are registered-state outputs plus one mux. There is no path from `in_*`.
- Stall release from FULL: the skid entry moves to main on the first `out_fire`, and `in_ready` returns to 1 in the next cycle.
- A flush at edge N gives `out_valid` = 0 and `out_data` = `BUBBLE` after edge N.

## Test plan

- Streaming: `DATA_W` = 64, `out_ready` = 1, present 0x1, 0x2, 0x3 on consecutive cycles. Required: `out_data` shows 0x1, 0x2, 0x3 one cycle later, with `out_valid` held at 1 throughout.
- Stall/skid: stream 0xA, 0xB, 0xC with `out_ready` = 0 from the cycle 0xA appears.
  - 0xA is held in main and 0xB goes to skid.
  - `in_ready` = 0 and 0xC is held upstream.
  - On release, output order is 0xA, 0xB, 0xC with no loss.
- Flush when FULL: fill with 0x10 and 0x11, assert `flush` with `out_ready` = 0. Required: next cycle `out_valid` = 0, `out_data` = `BUBBLE`, `flush_cnt` = 2.
- Flush with consume: state ONE, `flush` & `out_ready` in the same cycle. Required: `flush_cnt` unchanged, and the input offered that cycle is not accepted.
- Saturation: `CNT_W` = 2, perform four full flushes. Required: `flush_cnt` sticks at 3.
- Async reset mid-stream: assert `reset` between edges while FULL. Required:
  - `out_valid` = 0 and `out_data` = `BUBBLE` immediately.
  - `in_ready` = 0 while `reset` is high and 1 after release.
  - `flush_cnt` = 0.
